// File: rtl/multi_issue_dispatch_pkg.sv
// core_types: shared types for the dispatch stage.
//   id_dispatch_struct : decoded slot from the instruction buffer
//   dispatch_ex_struct : resolved operands + payload handed to EXE
//   fwd_entry_t        : one forwarding source (valid, addr, data)
// DEF_LAT_W is the default width of the result-latency field.
package core_types;

    localparam int unsigned DEF_LAT_W = 2;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_AW    = 5;
    localparam int unsigned PAYLOAD_W = 32;

    typedef struct packed {
        logic                           valid;
        logic [1:0]                     rs_valid;
        logic [1:0][REG_AW-1:0]         rs_addr;
        logic                           rd_valid;
        logic [REG_AW-1:0]              rd_addr;
        logic [DEF_LAT_W-1:0]           latency;
        logic                           serial;
        logic [PAYLOAD_W-1:0]           payload;
    } id_dispatch_struct;

    typedef struct packed {
        logic [1:0][XLEN-1:0]           rs_data;
        logic                           rd_valid;
        logic [REG_AW-1:0]              rd_addr;
        logic [DEF_LAT_W-1:0]           latency;
        logic                           serial;
        logic [PAYLOAD_W-1:0]           payload;
    } dispatch_ex_struct;

    typedef struct packed {
        logic                           valid;
        logic [REG_AW-1:0]              addr;
        logic [XLEN-1:0]                data;
    } fwd_entry_t;

endpackage

// File: rtl/dispatch_scoreboard.sv
// dispatch_scoreboard: per-register result-latency counters (r1..r31).
//   clk, rst_n   : clock, async active-low reset
//   clear_i      : zero every counter next edge (highest priority)
//   hold_i       : freeze decrement while the EXE output is held
//   set_valid_i  : per slot, slot issued this cycle
//   set_addr_i   : per slot destination register
//   set_lat_i    : per slot latency to load (0 = nothing tracked)
//   busy_o       : per register, counter nonzero (bit 0 always 0)
module dispatch_scoreboard
    import core_types::*;
#(
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned LAT_W       = DEF_LAT_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear_i,
    input  logic                                hold_i,
    input  logic [ISSUE_WIDTH-1:0]              set_valid_i,
    input  logic [ISSUE_WIDTH-1:0][REG_AW-1:0]  set_addr_i,
    input  logic [ISSUE_WIDTH-1:0][LAT_W-1:0]   set_lat_i,
    output logic [31:0]                         busy_o
);

    logic [31:1][LAT_W-1:0] cnt_q;
    logic [31:1][LAT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned r = 1; r < 32; r++) begin
            if (!hold_i && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
            // Ascending slot order: the youngest writer of r lands last.
            for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
                if (set_valid_i[i] && (set_addr_i[i] == REG_AW'(r)) &&
                    (set_lat_i[i] != '0)) begin
                    cnt_d[r] = set_lat_i[i];
                end
            end
        end
        if (clear_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        busy_o = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            busy_o[r] = (cnt_q[r] != '0);
        end
    end

endmodule

// File: rtl/multi_issue_dispatch.sv
// multi_issue_dispatch: in-order multi-issue dispatch with scoreboard
// hazard stalls, operand forwarding and a registered EXE output stage.
//   clk, rst_n              : clock, async active-low reset
//   flush                   : drop staged/in-flight work, clear counters
//   block                   : issue nothing this cycle
//   id_i                    : decoded slots (slot 0 oldest)
//   ib_accept_o             : slots consumed this cycle (= issue mask)
//   regfile_reg_read_addr_o : combinational regfile read address
//   regfile_reg_read_data_i : regfile read data
//   fwd_i                   : forwarding sources, index 0 highest priority
//   exe_valid_o, exe_o      : registered issue group to EXE
//   exe_ready_i             : EXE accepts the whole group
module multi_issue_dispatch
    import core_types::*;
#(
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned FWD_PORTS   = 4,
    parameter int unsigned LAT_W       = DEF_LAT_W
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        flush,
    input  logic                                        block,
    input  id_dispatch_struct [ISSUE_WIDTH-1:0]         id_i,
    output logic [ISSUE_WIDTH-1:0]                      ib_accept_o,
    output logic [ISSUE_WIDTH-1:0][1:0][REG_AW-1:0]     regfile_reg_read_addr_o,
    input  logic [ISSUE_WIDTH-1:0][1:0][XLEN-1:0]       regfile_reg_read_data_i,
    input  fwd_entry_t [FWD_PORTS-1:0]                  fwd_i,
    output logic [ISSUE_WIDTH-1:0]                      exe_valid_o,
    input  logic                                        exe_ready_i,
    output dispatch_ex_struct [ISSUE_WIDTH-1:0]         exe_o
);

    logic [ISSUE_WIDTH-1:0]                  exe_valid_q;
    dispatch_ex_struct [ISSUE_WIDTH-1:0]     exe_q;
    logic                                    held;
    logic [31:0]                             busy;
    logic [ISSUE_WIDTH-1:0]                  can_issue;
    logic [ISSUE_WIDTH-1:0]                  issue_mask;
    logic [ISSUE_WIDTH-1:0][1:0][XLEN-1:0]   opnd;
    dispatch_ex_struct [ISSUE_WIDTH-1:0]     ex_slot;
    logic [ISSUE_WIDTH-1:0][REG_AW-1:0]      sb_addr;
    logic [ISSUE_WIDTH-1:0][LAT_W-1:0]       sb_lat;
    logic [ISSUE_WIDTH-1:0]                  sb_set;

    assign held = (|exe_valid_q) && !exe_ready_i;

    // Per-slot eligibility: scoreboard busy sources and RAW on an older
    // same-group writer (which has no result yet to forward).
    always_comb begin
        logic stall;
        can_issue = '0;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            stall = 1'b0;
            for (int unsigned s = 0; s < 2; s++) begin
                if (id_i[i].rs_valid[s] && (id_i[i].rs_addr[s] != '0)) begin
                    if (busy[id_i[i].rs_addr[s]]) begin
                        stall = 1'b1;
                    end
                    for (int unsigned j = 0; j < i; j++) begin
                        if (id_i[j].valid && id_i[j].rd_valid &&
                            (id_i[j].rd_addr == id_i[i].rs_addr[s])) begin
                            stall = 1'b1;
                        end
                    end
                end
            end
            can_issue[i] = id_i[i].valid && !block && !flush && !held && !stall;
        end
    end

    // Prefix-contiguous mask; a serial slot only goes as slot 0 and then
    // closes the group behind it.
    always_comb begin
        logic go;
        logic ok;
        go         = 1'b1;
        issue_mask = '0;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            ok            = go && can_issue[i] && !(id_i[i].serial && (i != 0));
            issue_mask[i] = ok;
            go            = ok && !id_i[i].serial;
        end
    end

    assign ib_accept_o = issue_mask & {ISSUE_WIDTH{rst_n}};

    // Operand select: first (lowest-index) matching forward wins.
    always_comb begin
        logic found;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            for (int unsigned s = 0; s < 2; s++) begin
                regfile_reg_read_addr_o[i][s] = id_i[i].rs_addr[s];
                opnd[i][s] = regfile_reg_read_data_i[i][s];
                found      = 1'b0;
                for (int unsigned p = 0; p < FWD_PORTS; p++) begin
                    if (!found && fwd_i[p].valid && (fwd_i[p].addr != '0) &&
                        (fwd_i[p].addr == id_i[i].rs_addr[s])) begin
                        opnd[i][s] = fwd_i[p].data;
                        found      = 1'b1;
                    end
                end
                if (!id_i[i].rs_valid[s]) begin
                    opnd[i][s] = '0;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            ex_slot[i].rs_data  = opnd[i];
            ex_slot[i].rd_valid = id_i[i].rd_valid;
            ex_slot[i].rd_addr  = id_i[i].rd_addr;
            ex_slot[i].latency  = id_i[i].latency;
            ex_slot[i].serial   = id_i[i].serial;
            ex_slot[i].payload  = id_i[i].payload;
            sb_set[i]  = issue_mask[i] && id_i[i].rd_valid;
            sb_addr[i] = id_i[i].rd_addr;
            sb_lat[i]  = LAT_W'(id_i[i].latency);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_valid_q <= '0;
            exe_q       <= '0;
        end else if (flush) begin
            exe_valid_q <= '0;
            exe_q       <= '0;
        end else if (!held) begin
            exe_valid_q <= issue_mask;
            for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
                exe_q[i] <= issue_mask[i] ? ex_slot[i] : '0;
            end
        end
    end

    assign exe_valid_o = exe_valid_q;
    assign exe_o       = exe_q;

    dispatch_scoreboard #(
        .ISSUE_WIDTH (ISSUE_WIDTH),
        .LAT_W       (LAT_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (flush),
        .hold_i      (held),
        .set_valid_i (sb_set),
        .set_addr_i  (sb_addr),
        .set_lat_i   (sb_lat),
        .busy_o      (busy)
    );

endmodule

// File: doc/multi_issue_dispatch.md
MULTI_ISSUE_DISPATCH -- requirements
Module: multi_issue_dispatch

Interface
REQ-001 SHALL have parameter ISSUE_WIDTH, default 2, number of dispatch slots, legal range 1..4.
REQ-002 SHALL have parameter FWD_PORTS, default 4, number of forwarding sources.
REQ-003 SHALL have parameter LAT_W, default 2, bit width of result-latency field; max latency 2^LAT_W-1.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  discard staged and in-flight work.
REQ-007 block  in  1  issue nothing this cycle.
REQ-008 id_i  in  ISSUE_WIDTH x id_dispatch_struct  decoded slots: valid, rs_valid[2], rs_addr[2], rd_valid, rd_addr, latency (LAT_W), serial flag, payload.
REQ-009 ib_accept_o  out  ISSUE_WIDTH  slots consumed this cycle.
REQ-010 regfile_reg_read_addr_o / regfile_reg_read_data_i  out/in  ISSUE_WIDTH x 2 x 5 / x 32  combinational regfile read.
REQ-011 fwd_i  in  FWD_PORTS x {valid, addr[5], data[32]}  forwarding; lower index = younger, higher priority.
REQ-012 exe_valid_o  out  ISSUE_WIDTH  registered slot valid to EXE.
REQ-013 exe_ready_i  in  1  EXE accepts whole group.
REQ-014 exe_o  out  ISSUE_WIDTH x dispatch_ex_struct  registered operands and payload.

Function
REQ-015 Issue mask SHALL be prefix-contiguous: slot i issues only if all slots j<i issue.
REQ-016 Slot i SHALL NOT issue if: invalid, block, flush, output held (REQ-022), scoreboard counter nonzero for any valid nonzero source, or any source equals rd_addr of an older same-group slot with rd_valid.
REQ-017 A slot with serial=1 SHALL issue only as slot 0, alone; a serial slot i>0 stops issue at i.
REQ-018 ib_accept_o SHALL equal the issue mask.
REQ-019 Scoreboard: one LAT_W counter per register 1..31; register 0 never tracked, never stalls, never forwarded.
REQ-020 On issue of a writer with latency L (L>=1), counter[rd] SHALL load L; when several issued slots write one rd, youngest slot's L wins; load overrides decrement in same cycle.
REQ-021 Nonzero counters SHALL decrement by 1 per cycle except while output held; saturate at 0.
REQ-022 Output held when any exe_valid_o=1 and exe_ready_i=0; exe_o and exe_valid_o SHALL then stay unchanged.
REQ-023 When not held, exe_valid_o SHALL load the issue mask and exe_o the issued slots; non-issued slots SHALL be zeroed; latency accept-to-exe_valid_o = 1 cycle.
REQ-024 Operand select SHALL be highest-priority matching valid fwd_i entry with addr!=0, else regfile data; source not valid yields 0.
REQ-025 flush SHALL clear exe_valid_o, exe_o and all counters next edge, overriding issue, hold and block.

Reset
REQ-026 On rst_n low, exe_valid_o=0, exe_o=0, all counters=0, asynchronously; ib_accept_o=0 while in reset.
REQ-027 After rst_n rises, first issue SHALL be possible in the first cycle.

Structure
REQ-028 id_dispatch_struct, dispatch_ex_struct, forwarding entry type and LAT_W default SHALL live in core_types package.
REQ-029 Scoreboard SHALL be sub-module dispatch_scoreboard (counters, set/decrement/clear, per-register busy vector).
REQ-030 Operand mux and issue-mask logic SHALL stay in multi_issue_dispatch.

Verification
REQ-031 Two valid ALU slots, r1<-r2+r3 and r4<-r5+r6, no hazards -> ib_accept_o=2'b11, exe_valid_o=2'b11 next cycle.
REQ-032 Slot1 reads r1 written by slot0 -> ib_accept_o=2'b01; slot1 issues next cycle with operand from fwd_i[0].
REQ-033 Load r7 with L=3 issued, consumer of r7 waiting -> consumer stalled exactly 3 cycles, issues in 4th with forwarded data.
REQ-034 exe_ready_i=0 for 2 cycles with exe_valid_o=2'b11 -> exe_o stable, ib_accept_o=0, counters frozen; resumes at ready.
REQ-035 flush with counter[r9]=2 and staged group -> next cycle exe_valid_o=0, counter[r9]=0; reader of r9 issues immediately.
REQ-036 rst_n asserted mid-hold -> outputs zero immediately without clk edge; serial slot1 with slot0 ALU -> ib_accept_o=2'b01.
